// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX frame checker
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STP_ONE  = 1'b0;
    localparam logic STP_TWO  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_chk_if.sv
// rtl/uart_rx_frame_chk_if.sv - sampler strobes, frame config, results and counters
interface uart_rx_frame_chk_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  start_en;
    logic                  bit_vld;
    logic                  sample_bit;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STP_NUM;
    logic                  clr_cnt;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  frame_done;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;

    modport master (
        output start_en, bit_vld, sample_bit, PAR_EN, PAR_TYP, STP_NUM, clr_cnt,
        input  data_out, data_valid, frame_done, par_err, stp_err, strt_glitch,
               par_err_cnt, stp_err_cnt
    );

    modport slave (
        input  start_en, bit_vld, sample_bit, PAR_EN, PAR_TYP, STP_NUM, clr_cnt,
        output data_out, data_valid, frame_done, par_err, stp_err, strt_glitch,
               par_err_cnt, stp_err_cnt
    );
endinterface

// File: rtl/sat_err_cnt.sv
// rtl/sat_err_cnt.sv - saturating error event counter with synchronous clear
module sat_err_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_frame_chk.sv
// rtl/uart_rx_frame_chk.sv - UART RX frame tracker: start/parity/stop checks, data word, error counters
module uart_rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_frame_chk_if.slave bus
);
    localparam int             BW       = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             state, state_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cfg_par_en, cfg_par_typ, cfg_stp_num;
    logic                  par_bad, stp_bad;
    logic                  frame_done_q, data_valid_q, par_err_q, stp_err_q, glitch_q;
    logic                  last_stop, stp_bad_fin;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stp_bad_fin = stp_bad | ~bus.sample_bit;
        last_stop   = bus.bit_vld &&
                      ((state == S_STOP1 && cfg_stp_num == STP_ONE) || state == S_STOP2);
        case (state)
            S_IDLE:   if (bus.start_en) state_nxt = S_START;
            S_START:  if (bus.bit_vld) state_nxt = bus.sample_bit ? S_IDLE : S_DATA;
            S_DATA:   if (bus.bit_vld && bit_cnt == LAST_BIT)
                          state_nxt = cfg_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (bus.bit_vld) state_nxt = S_STOP1;
            S_STOP1:  if (bus.bit_vld) state_nxt = (cfg_stp_num == STP_TWO) ? S_STOP2 : S_DONE;
            S_STOP2:  if (bus.bit_vld) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Result pulses are registered on the final stop strobe so they coincide with the DONE cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            data_q       <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_typ  <= 1'b0;
            cfg_stp_num  <= 1'b0;
            par_bad      <= 1'b0;
            stp_bad      <= 1'b0;
            frame_done_q <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            glitch_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            glitch_q     <= 1'b0;
            case (state)
                S_IDLE: if (bus.start_en) begin
                    cfg_par_en  <= bus.PAR_EN;
                    cfg_par_typ <= bus.PAR_TYP;
                    cfg_stp_num <= bus.STP_NUM;
                    par_bad     <= 1'b0;
                    stp_bad     <= 1'b0;
                    bit_cnt     <= '0;
                end
                S_START: if (bus.bit_vld) begin
                    glitch_q <= bus.sample_bit;
                    bit_cnt  <= '0;
                end
                S_DATA: if (bus.bit_vld) begin
                    shreg   <= {bus.sample_bit, shreg[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_PARITY: if (bus.bit_vld) begin
                    par_bad <= ((^shreg) ^ cfg_par_typ) != bus.sample_bit;
                end
                S_STOP1, S_STOP2: if (bus.bit_vld) begin
                    stp_bad <= stp_bad_fin;
                    if (last_stop) begin
                        frame_done_q <= 1'b1;
                        par_err_q    <= par_bad;
                        stp_err_q    <= stp_bad_fin;
                        if (!par_bad && !stp_bad_fin) begin
                            data_valid_q <= 1'b1;
                            data_q       <= shreg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.frame_done  = frame_done_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.strt_glitch = glitch_q;
    assign bus.data_out    = data_q;

    sat_err_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc   (par_err_q),
        .clr   (bus.clr_cnt),
        .cnt   (bus.par_err_cnt)
    );

    sat_err_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc   (stp_err_q),
        .clr   (bus.clr_cnt),
        .cnt   (bus.stp_err_cnt)
    );
endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb/tb_uart_rx_frame_chk.sv - directed table-driven bench for uart_rx_frame_chk
module tb_uart_rx_frame_chk;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic       r_fd, r_dv, r_pe, r_se;
    logic [7:0] r_dout;

    always #5 clk = ~clk;

    uart_rx_frame_chk_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

    uart_rx_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe, pt, sn, pb, s1, s2;
        logic       fd, dv, perr, serr;
        logic [7:0] dout, pcnt, scnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic pe, input logic pt, input logic sn);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bus.STP_NUM  = sn;
        bus.start_en = 1'b1;
        tick();
        bus.start_en = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        bus.bit_vld    = 1'b1;
        bus.sample_bit = b;
        tick();
        bus.bit_vld    = 1'b0;
    endtask

    // Outputs are captured right after the edge that consumed the last stop strobe.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic sn, input logic pb, input logic s1, input logic s2);
        start_frame(pe, pt, sn);
        send_bit(1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            tick();
        end
        if (pe) begin
            send_bit(pb);
            tick();
        end
        send_bit(s1);
        if (sn) begin
            tick();
            send_bit(s2);
        end
        r_fd   = bus.frame_done;
        r_dv   = bus.data_valid;
        r_pe   = bus.par_err;
        r_se   = bus.stp_err;
        r_dout = bus.data_out;
    endtask

    initial begin
        //             d      pe    pt    sn    pb    s1    s2    fd    dv    perr  serr  dout   pcnt   scnt
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'd0, 8'd0};
        tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd0, 8'd1};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'd1, 8'd1};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'd1, 8'd1};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'd1, 8'd1};
        tbl[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'd2, 8'd2};
        tbl[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd2, 8'd3};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd2, 8'd3};

        bus.start_en   = 1'b0;
        bus.bit_vld    = 1'b0;
        bus.sample_bit = 1'b1;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.STP_NUM    = 1'b0;
        bus.clr_cnt    = 1'b0;
        repeat (3) tick();
        chk1("rst_frame_done", bus.frame_done, 1'b0);
        chk1("rst_data_valid", bus.data_valid, 1'b0);
        chk8("rst_data_out", bus.data_out, 8'h00);
        chk8("rst_par_cnt", bus.par_err_cnt, 8'd0);
        chk8("rst_stp_cnt", bus.stp_err_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            send_frame(tbl[v].d, tbl[v].pe, tbl[v].pt, tbl[v].sn, tbl[v].pb, tbl[v].s1, tbl[v].s2);
            chk1($sformatf("v%0d_frame_done", v), r_fd, tbl[v].fd);
            chk1($sformatf("v%0d_data_valid", v), r_dv, tbl[v].dv);
            chk1($sformatf("v%0d_par_err", v), r_pe, tbl[v].perr);
            chk1($sformatf("v%0d_stp_err", v), r_se, tbl[v].serr);
            chk8($sformatf("v%0d_data_out", v), r_dout, tbl[v].dout);
            tick();
            chk1($sformatf("v%0d_done_width", v), bus.frame_done, 1'b0);
            chk8($sformatf("v%0d_par_cnt", v), bus.par_err_cnt, tbl[v].pcnt);
            chk8($sformatf("v%0d_stp_cnt", v), bus.stp_err_cnt, tbl[v].scnt);
        end

        start_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
        chk1("glitch_pulse", bus.strt_glitch, 1'b1);
        chk1("glitch_no_done", bus.frame_done, 1'b0);
        tick();
        chk1("glitch_width", bus.strt_glitch, 1'b0);
        chk1("glitch_no_done2", bus.frame_done, 1'b0);
        send_bit(1'b0);
        tick();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("after_glitch_valid", r_dv, 1'b1);
        chk8("after_glitch_data", r_dout, 8'h3C);
        tick();
        chk8("glitch_par_cnt", bus.par_err_cnt, 8'd2);
        chk8("glitch_stp_cnt", bus.stp_err_cnt, 8'd3);

        start_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.STP_NUM = 1'b1;
                bus.PAR_EN  = 1'b1;
            end
            bus.start_en = (i == 2);
            send_bit(i[0] ? 1'b0 : 1'b1);
            bus.start_en = 1'b0;
            tick();
        end
        send_bit(1'b1);
        chk1("toggle_one_stop_done", bus.frame_done, 1'b1);
        chk1("toggle_valid", bus.data_valid, 1'b1);
        chk8("toggle_data", bus.data_out, 8'h55);
        bus.STP_NUM = 1'b0;
        bus.PAR_EN  = 1'b0;
        tick();

        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("clr_stp_err", r_se, 1'b1);
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk8("clr_wins_stp", bus.stp_err_cnt, 8'd0);
        chk8("clr_par", bus.par_err_cnt, 8'd0);

        for (int n = 1; n <= 260; n++) begin
            send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            if (n == 10) chk8("sat_par_cnt_10", bus.par_err_cnt, 8'd10);
        end
        chk8("sat_par_cnt", bus.par_err_cnt, 8'd255);
        chk8("sat_stp_cnt", bus.stp_err_cnt, 8'd0);
        chk1("sat_last_par_err", r_pe, 1'b1);

        start_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk8("midrst_data_out", bus.data_out, 8'h00);
        chk8("midrst_par_cnt", bus.par_err_cnt, 8'd0);
        chk1("midrst_done", bus.frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1);
            chk1($sformatf("midrst_idle_%0d", i), bus.frame_done, 1'b0);
            tick();
        end
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("post_rst_valid", r_dv, 1'b1);
        chk8("post_rst_data", r_dout, 8'h96);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
